serializer: RTL and testbench

SERIALIZER -- requirements
Module: serializer

---
 rtl/serializer.sv | 134 +++++++++++++
 tb/tb_serializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// Parallel-to-serial shifter with valid/ready handshake on the serial side.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module serializer #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] D,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         serial_out,
  output logic         serial_valid,
  input  logic         serial_ready,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef SERIALIZER_PARITY_EN
    PARITY = 2'd2,
`endif
    SHIFT  = 2'd1
  } state_t;

  state_t         state_reg;
  logic [N-1:0]   shreg_reg;
  logic [CW-1:0]  cnt_reg;
  logic           load_ready_reg;
  logic           serial_valid_reg;
  logic           busy_reg;
  logic           done_reg;
  logic [N-1:0]   shreg_next;
`ifdef SERIALIZER_PARITY_EN
  logic           parity_reg;
`endif

  // Shift toward the output end; zeros fill in so the register drains to 0.
  always_comb begin
    shreg_next = '0;
    if (MSB_FIRST)
      shreg_next = shreg_reg << 1;
    else
      shreg_next = shreg_reg >> 1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      shreg_reg        <= '0;
      cnt_reg          <= '0;
      load_ready_reg   <= 1'b1;
      serial_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_reg       <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load_valid) begin
            shreg_reg        <= D;
            cnt_reg          <= '0;
`ifdef SERIALIZER_PARITY_EN
            parity_reg       <= ^D;
`endif
            state_reg        <= SHIFT;
            load_ready_reg   <= 1'b0;
            serial_valid_reg <= 1'b1;
            busy_reg         <= 1'b1;
          end
        end
        SHIFT: begin
          if (serial_ready) begin
            shreg_reg <= shreg_next;
            cnt_reg   <= cnt_reg + CW'(1);
            if (cnt_reg == LAST) begin
`ifdef SERIALIZER_PARITY_EN
              state_reg        <= PARITY;
`else
              state_reg        <= IDLE;
              load_ready_reg   <= 1'b1;
              serial_valid_reg <= 1'b0;
              busy_reg         <= 1'b0;
              done_reg         <= 1'b1;
`endif
            end
          end
        end
`ifdef SERIALIZER_PARITY_EN
        PARITY: begin
          if (serial_ready) begin
            state_reg        <= IDLE;
            load_ready_reg   <= 1'b1;
            serial_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b1;
          end
        end
`endif
        default: begin
          state_reg        <= IDLE;
          load_ready_reg   <= 1'b1;
          serial_valid_reg <= 1'b0;
          busy_reg         <= 1'b0;
        end
      endcase
    end
  end

  // Output bit is gated by state so it reads 0 whenever nothing is in flight.
  always_comb begin
    serial_out = 1'b0;
    case (state_reg)
      SHIFT:   serial_out = MSB_FIRST ? shreg_reg[N-1] : shreg_reg[0];
`ifdef SERIALIZER_PARITY_EN
      PARITY:  serial_out = parity_reg;
`endif
      default: serial_out = 1'b0;
    endcase
  end

  assign load_ready   = load_ready_reg;
  assign serial_valid = serial_valid_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_serializer.sv
// Scoreboard bench: two serializers (LSB-first and MSB-first) share stimulus;
// expected bit pairs are queued by the driver and popped by a negedge monitor.
module tb_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int BITS = 8 + PAR;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] D = 8'h00;
  logic       load_valid = 1'b0;
  logic       serial_ready = 1'b1;
  logic [1:0] lr, so, sv, bz, dn;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int exp_done[$];
  int mon_e, mon_id, lat, vc, cyc, t1, t2, ndone, xfers;
  bit seen;
  logic [3:0] pat;

  serializer #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .reset(reset), .D(D), .load_valid(load_valid),
    .load_ready(lr[0]), .serial_out(so[0]), .serial_valid(sv[0]),
    .serial_ready(serial_ready), .busy(bz[0]), .done(dn[0]));

  serializer #(.N(8), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .reset(reset), .D(D), .load_valid(load_valid),
    .load_ready(lr[1]), .serial_out(so[1]), .serial_valid(sv[1]),
    .serial_ready(serial_ready), .busy(bz[1]), .done(dn[1]));

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Each entry: word id in the upper bits, {msb_first_bit, lsb_first_bit} in [1:0].
  task automatic push_word(input logic [7:0] d, input int id);
    for (int b = 0; b < 8; b++)
      exp_q.push_back((id << 2) | int'({d[7-b], d[b]}));
    if (PAR == 1)
      exp_q.push_back((id << 2) | int'({^d, ^d}));
    exp_done.push_back(id);
  endtask

  task automatic send_word(input logic [7:0] d, input int id);
    int l;
    @(posedge clock); #1;
    D = d; load_valid = 1'b1; push_word(d, id);
    @(posedge clock); #1;
    load_valid = 1'b0;
    @(negedge clock);
    check($sformatf("busy_w%0d", id), 32'(bz), 32'h3);
    check($sformatf("load_ready_w%0d", id), 32'(lr), 32'h0);
    l = 1;
    while (!dn[0] && l < 200) begin
      @(negedge clock);
      l++;
    end
    check($sformatf("latency_w%0d", id), 32'(l), 32'(BITS + 1));
    $display("[TB] word %0d D=%02h done after %0d cycles", id, d, l);
  endtask

  // Monitor: compare transferred/stalled bits against the queue head, and done pulses.
  always @(negedge clock) begin
    if (!reset) begin
      if ((sv & {2{serial_ready}}) != 2'b00) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL extra_bit: serial_valid=%b with nothing expected", sv);
        end else begin
          mon_e = exp_q.pop_front();
          for (int i = 0; i < 2; i++) begin
            check($sformatf("valid%0d_w%0d", i, mon_e >> 2), 32'(sv[i]), 32'h1);
            check($sformatf("bit%0d_w%0d", i, mon_e >> 2), 32'(so[i]), 32'(mon_e[i]));
          end
        end
      end else if (sv != 2'b00 && exp_q.size() > 0) begin
        mon_e = exp_q[0];
        for (int i = 0; i < 2; i++)
          check($sformatf("hold%0d_w%0d", i, mon_e >> 2), 32'(so[i]), 32'(mon_e[i]));
      end
      if (dn != 2'b00) begin
        if (exp_done.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL unexpected_done: done=%b", dn);
        end else begin
          mon_id = exp_done.pop_front();
          check($sformatf("done_both_w%0d", mon_id), 32'(dn), 32'h3);
          check($sformatf("done_idle_w%0d", mon_id), 32'({bz, sv}), 32'h0);
          check($sformatf("bits_left_w%0d", mon_id),
                32'(exp_q.size() > 0 && (exp_q[0] >> 2) == mon_id), 32'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_load_ready", 32'(lr), 32'h3);
    check("reset_outputs", 32'({sv, bz, so, dn}), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    send_word(8'hA5, 1);
    send_word(8'h01, 2);

    // Stalled word with spurious load pulses while busy.
    @(posedge clock); #1;
    D = 8'h3C; load_valid = 1'b1; push_word(8'h3C, 3);
    @(posedge clock);
    pat = 4'b1001; seen = 1'b0; xfers = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      #1;
      serial_ready = pat[c % 4];
      load_valid   = (c == 2 || c == 5);
      D            = 8'hFF;
      @(negedge clock);
      if (sv[0] && serial_ready) xfers++;
      if (dn[0]) seen = 1'b1;
      @(posedge clock);
    end
    #1 serial_ready = 1'b1;
    check("stall_done_seen", 32'(seen), 32'h1);
    check("stall_transfers", 32'(xfers), 32'(BITS));
    $display("[TB] word 3 D=3c stalled, %0d transfers", xfers);

    send_word(8'h07, 4);

    // Abort after three bits.
    @(posedge clock); #1;
    D = 8'hFF; load_valid = 1'b1; push_word(8'hFF, 5);
    @(posedge clock); #1;
    load_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    exp_q.delete();
    exp_done.delete();
    @(negedge clock);
    check("abort_load_ready", 32'(lr), 32'h3);
    check("abort_outputs", 32'({sv, bz, so, dn}), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("abort_idle", 32'({lr, bz}), 32'hC);
    $display("[TB] word 5 D=ff aborted by reset");
    send_word(8'h0F, 6);

    // Back-to-back words with load_valid held high.
    @(posedge clock); #1;
    D = 8'h12; load_valid = 1'b1; push_word(8'h12, 7); push_word(8'h34, 8);
    @(posedge clock); #1;
    D = 8'h34;
    vc = 0; cyc = 0; t1 = 0; t2 = 0; ndone = 0;
    while (ndone < 2 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (sv[0]) vc++;
      if (dn[0]) begin
        ndone++;
        if (ndone == 1) begin
          t1 = cyc;
          check("b2b_done_ready", 32'(lr), 32'h3);
          @(posedge clock); #1;
          load_valid = 1'b0;
        end else begin
          t2 = cyc;
        end
      end
    end
    load_valid = 1'b0;
    check("b2b_first_done", 32'(t1), 32'(BITS + 1));
    check("b2b_gap", 32'(t2 - t1), 32'(BITS + 1));
    check("b2b_valid_cycles", 32'(vc), 32'(2 * BITS));
    $display("[TB] words 7,8 D=12,34 back-to-back, %0d valid cycles", vc);

    repeat (4) @(negedge clock);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    check("done_queue_empty", 32'(exp_done.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
